// File: rtl/stream_pkg.sv
// Shared stream definitions used by the even/odd demux and the interleave merge.
package stream_pkg;

  localparam int DEF_DATA_WIDTH = 1024;
  localparam int DEF_FIFO_DEPTH = 8;

  // Lane selector for the even/odd split; even lane always goes first after reset/clear.
  typedef enum logic {
    LANE_EVEN = 1'b0,
    LANE_ODD  = 1'b1
  } lane_e;

  // Pointer width carries one extra wrap bit so full and empty can be told apart.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// Merge FIFO: unreset storage, wrap-bit pointers, full/empty flags and occupancy.
module stream_fifo
  import stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  localparam int PW = ptr_w(FIFO_DEPTH),
  localparam int AW = PW - 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [PW-1:0]         level
);

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic                  do_wr;
  logic                  do_rd;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign level = wr_ptr_q - rd_ptr_q;

  assign do_wr = wr_en && !full && !clr;
  assign do_rd = rd_en && !empty && !clr;

  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_rd) rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage has no reset; stale entries are unreachable once the pointers are cleared.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/data_interleave_mux.sv
// Restores original beat order from the even/odd lanes into one registered stream.
// state     | meaning
// LANE_EVEN | next beat must come from port 0 (data_in0)
// LANE_ODD  | next beat must come from port 1 (data_in1)
module data_interleave_mux
  import stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  localparam int PW = ptr_w(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic [DATA_WIDTH-1:0] data_in0,
  input  logic                  valid_in0,
  output logic                  ready_in0,
  input  logic [DATA_WIDTH-1:0] data_in1,
  input  logic                  valid_in1,
  output logic                  ready_in1,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  ready_out,
  output logic [PW-1:0]         fifo_level,
  output logic [31:0]           beat_cnt
);

  lane_e                 sel_q, sel_d;
  logic                  valid_out_q, valid_out_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic [31:0]           beat_cnt_q, beat_cnt_d;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  accept;
  logic                  load;
  logic                  out_hs;

  // Ready depends only on registered state so upstream never sees a valid->ready loop.
  assign ready_in0 = (sel_q == LANE_EVEN) && !fifo_full;
  assign ready_in1 = (sel_q == LANE_ODD) && !fifo_full;

  assign accept  = (valid_in0 && ready_in0) || (valid_in1 && ready_in1);
  assign wr_data = (sel_q == LANE_ODD) ? data_in1 : data_in0;
  assign load    = !fifo_empty && (!valid_out_q || ready_out);
  assign out_hs  = valid_out_q && ready_out;

  stream_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr),
    .wr_en  (accept),
    .wr_data(wr_data),
    .rd_en  (load),
    .rd_data(fifo_rd_data),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (fifo_level)
  );

  always_comb begin
    sel_d = sel_q;
    if (clr) begin
      sel_d = LANE_EVEN;
    end else if (accept) begin
      case (sel_q)
        LANE_EVEN: sel_d = LANE_ODD;
        LANE_ODD:  sel_d = LANE_EVEN;
        default:   sel_d = LANE_EVEN;
      endcase
    end
  end

  always_comb begin
    valid_out_d = valid_out_q;
    data_out_d  = data_out_q;
    beat_cnt_d  = beat_cnt_q;
    if (clr) begin
      valid_out_d = 1'b0;
      data_out_d  = '0;
      beat_cnt_d  = '0;
    end else begin
      if (load) begin
        valid_out_d = 1'b1;
        data_out_d  = fifo_rd_data;
      end else if (out_hs) begin
        valid_out_d = 1'b0;
      end
      if (out_hs) beat_cnt_d = beat_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q       <= LANE_EVEN;
      valid_out_q <= 1'b0;
      data_out_q  <= '0;
      beat_cnt_q  <= '0;
    end else begin
      sel_q       <= sel_d;
      valid_out_q <= valid_out_d;
      data_out_q  <= data_out_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_data_interleave_mux.sv
// Directed bench for data_interleave_mux with an in-order scoreboard on the output handshake.
module tb_data_interleave_mux;

  localparam int DW = 1024;
  localparam int DEPTH = 8;
  localparam int PW = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst_n;
  logic          clr;
  logic [DW-1:0] data_in0;
  logic          valid_in0;
  logic          ready_in0;
  logic [DW-1:0] data_in1;
  logic          valid_in1;
  logic          ready_in1;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          ready_out;
  logic [PW-1:0] fifo_level;
  logic [31:0]   beat_cnt;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] sb[$];
  int            lane = 0;
  bit            rnd_rdy = 0;
  bit            prev_stall = 0;
  logic [DW-1:0] prev_data = '0;
  logic [DW-1:0] exp_d;

  data_interleave_mux #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .data_in0  (data_in0),
    .valid_in0 (valid_in0),
    .ready_in0 (ready_in0),
    .data_in1  (data_in1),
    .valid_in1 (valid_in1),
    .ready_in1 (ready_in1),
    .data_out  (data_out),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .fifo_level(fifo_level),
    .beat_cnt  (beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_data(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers d on the lane the merge should want next; pushes it to the scoreboard on accept.
  task automatic send_next(input logic [DW-1:0] d, input int budget);
    bit ok;
    ok = 0;
    if (lane == 0) begin data_in0 = d; valid_in0 = 1'b1; end
    else begin data_in1 = d; valid_in1 = 1'b1; end
    for (int i = 0; i < budget; i++) begin
      if (rnd_rdy) ready_out = 1'($urandom_range(0, 1));
      @(negedge clk);
      if ((lane == 0 && ready_in0) || (lane == 1 && ready_in1)) begin
        sb.push_back(d);
        ok = 1;
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
    end
    valid_in0 = 1'b0;
    valid_in1 = 1'b0;
    checks++;
    assert (ok)
    else begin
      errors++;
      $error("FAIL send_timeout: lane %0d observed no ready, expected ready within %0d cycles", lane, budget);
    end
    if (ok) lane = 1 - lane;
  endtask

  // Output monitor: in-order compare on each handshake, stability check across stalls.
  always @(negedge clk) begin
    if (rst_n && prev_stall) begin
      chk("stall_valid_held", 64'(valid_out), 64'd1);
      chk_data("stall_data_held", data_out, prev_data);
    end
    if (rst_n && !clr && valid_out && ready_out) begin
      checks++;
      assert (sb.size() != 0)
      else begin
        errors++;
        $error("FAIL unexpected_out: observed data %0h, expected no output", data_out);
      end
      if (sb.size() != 0) begin
        exp_d = sb.pop_front();
        chk_data("out_order", data_out, exp_d);
      end
    end
    prev_stall = rst_n && !clr && valid_out && !ready_out;
    prev_data  = data_out;
  end

  initial begin
    rst_n = 1'b0;
    clr = 1'b0;
    data_in0 = '0;
    data_in1 = '0;
    valid_in0 = 1'b0;
    valid_in1 = 1'b0;
    ready_out = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // 1: reset state, then A0/A1 with 2-edge latency
    chk("rst_ready_in0", 64'(ready_in0), 64'd1);
    chk("rst_ready_in1", 64'(ready_in1), 64'd0);
    chk("rst_valid_out", 64'(valid_out), 64'd0);
    chk_data("rst_data_out", data_out, '0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_beat_cnt", 64'(beat_cnt), 64'd0);
    ready_out = 1'b1;
    send_next(DW'(32'hA0), 4);
    chk("t1_no_bypass", 64'(valid_out), 64'd0);
    chk("t1_level_1", 64'(fifo_level), 64'd1);
    send_next(DW'(32'hA1), 4);
    chk("t1_latency_valid", 64'(valid_out), 64'd1);
    chk_data("t1_first_data", data_out, DW'(32'hA0));
    repeat (4) step();
    chk("t1_beat_cnt", 64'(beat_cnt), 64'd2);
    chk("t1_drained", 64'(sb.size()), 64'd0);

    // 2: odd lane valid from reset must wait for the even lane
    rst_n = 1'b0;
    data_in1 = DW'(32'h55);
    valid_in1 = 1'b1;
    step();
    rst_n = 1'b1;
    lane = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_ready_in1_low", 64'(ready_in1), 64'd0);
      chk("t2_no_output", 64'(valid_out), 64'd0);
    end
    data_in0 = DW'(32'hAA);
    valid_in0 = 1'b1;
    send_next(DW'(32'hAA), 4);
    send_next(DW'(32'h55), 4);
    repeat (5) step();
    chk("t2_beat_cnt", 64'(beat_cnt), 64'd2);
    chk("t2_drained", 64'(sb.size()), 64'd0);

    // 3: fill to full with downstream stalled, then drain in order
    ready_out = 1'b0;
    for (int i = 0; i < 9; i++) send_next(DW'(32'h300 + i), 4);
    if (lane == 0) begin data_in0 = DW'(32'h3FF); valid_in0 = 1'b1; end
    else begin data_in1 = DW'(32'h3FF); valid_in1 = 1'b1; end
    step();
    chk("t3_level_full", 64'(fifo_level), 64'd8);
    chk("t3_ready_in0_full", 64'(ready_in0), 64'd0);
    chk("t3_ready_in1_full", 64'(ready_in1), 64'd0);
    chk("t3_valid_held", 64'(valid_out), 64'd1);
    chk_data("t3_first_held", data_out, DW'(32'h300));
    repeat (3) step();
    ready_out = 1'b1;
    chk("t3_no_writethrough0", 64'(ready_in0), 64'd0);
    chk("t3_no_writethrough1", 64'(ready_in1), 64'd0);
    valid_in0 = 1'b0;
    valid_in1 = 1'b0;
    repeat (12) step();
    chk("t3_drained", 64'(sb.size()), 64'd0);
    chk("t3_beat_cnt", 64'(beat_cnt), 64'd11);
    chk("t3_level_empty", 64'(fifo_level), 64'd0);

    // 4: 20-beat stream under random backpressure
    rnd_rdy = 1;
    for (int i = 0; i < 20; i++) send_next(DW'(32'h400 + i), 40);
    rnd_rdy = 0;
    ready_out = 1'b1;
    repeat (25) step();
    chk("t4_drained", 64'(sb.size()), 64'd0);
    chk("t4_beat_cnt", 64'(beat_cnt), 64'd31);

    // 5: synchronous clear with data in flight drops the concurrent input handshake
    ready_out = 1'b0;
    for (int i = 0; i < 4; i++) send_next(DW'(32'h500 + i), 4);
    chk("t5_level_3", 64'(fifo_level), 64'd3);
    chk("t5_valid_before", 64'(valid_out), 64'd1);
    if (lane == 0) begin data_in0 = DW'(32'h5EE); valid_in0 = 1'b1; end
    else begin data_in1 = DW'(32'h5EE); valid_in1 = 1'b1; end
    clr = 1'b1;
    step();
    clr = 1'b0;
    valid_in0 = 1'b0;
    valid_in1 = 1'b0;
    sb.delete();
    lane = 0;
    chk("t5_level_0", 64'(fifo_level), 64'd0);
    chk("t5_valid_0", 64'(valid_out), 64'd0);
    chk_data("t5_data_0", data_out, '0);
    chk("t5_beat_cnt_0", 64'(beat_cnt), 64'd0);
    chk("t5_ready_in0", 64'(ready_in0), 64'd1);
    chk("t5_ready_in1", 64'(ready_in1), 64'd0);
    ready_out = 1'b1;
    send_next(DW'(32'h5A0), 4);
    send_next(DW'(32'h5A1), 4);
    repeat (5) step();
    chk("t5_restart_cnt", 64'(beat_cnt), 64'd2);
    chk("t5_drained", 64'(sb.size()), 64'd0);

    // 6: asynchronous reset mid-stream
    ready_out = 1'b0;
    for (int i = 0; i < 3; i++) send_next(DW'(32'h600 + i), 4);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 64'(valid_out), 64'd0);
    chk_data("t6_async_data", data_out, '0);
    chk("t6_async_level", 64'(fifo_level), 64'd0);
    chk("t6_async_beat_cnt", 64'(beat_cnt), 64'd0);
    chk("t6_async_ready_in1", 64'(ready_in1), 64'd0);
    sb.delete();
    lane = 0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("t6_restart_port0", 64'(ready_in0), 64'd1);
    ready_out = 1'b1;
    send_next(DW'(32'h6A0), 4);
    send_next(DW'(32'h6A1), 4);
    repeat (5) step();
    chk("t6_restart_cnt", 64'(beat_cnt), 64'd2);
    chk("t6_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
